// File: rtl/serial_reduce_pkg.sv
// Shared types and the default result-width helper for the serial reduction engine.
package serial_reduce_pkg;

   typedef enum logic [1:0] {
      SUM   = 2'd0,
      SQSUM = 2'd1,
      MAX   = 2'd2,
      MIN   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      SEND = 2'd3
   } state_e;

   // Wide enough for N_WORDS maximal squares without overflow.
   function automatic int calc_out_w(input int data_w, input int n_words);
      return data_w + data_w + $clog2(n_words);
   endfunction

endpackage

// File: rtl/serial_reduce_if.sv
// Frame input strobe/data and serial result lines of the reduction engine.
interface serial_reduce_if #(
   parameter int DATA_W = 4
) ();
   logic              in_valid;
   logic [1:0]        in_mode;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_data;

   modport master (
      output in_valid, in_mode, in_data,
      input  out_valid, out_data
   );

   modport slave (
      input  in_valid, in_mode, in_data,
      output out_valid, out_data
   );
endinterface

// File: rtl/serial_reduce_unit_piso_shift.sv
// Parallel-load, MSB-first shift register; o_done flags the last bit of the word.
module piso_shift #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_data,
   input  logic         i_shift,
   output logic         o_msb,
   output logic         o_done
);
   localparam int            BC_W = $clog2(W);
   localparam logic [BC_W-1:0] LAST = BC_W'(W - 1);
   localparam logic [BC_W-1:0] ONE  = BC_W'(32'd1);

   logic [W-1:0]    r_sreg;
   logic [BC_W-1:0] r_bcnt;

   // Shift register and bit counter; load takes priority over shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sreg <= {W{1'b0}};
         r_bcnt <= {BC_W{1'b0}};
      end else if (i_load) begin
         r_sreg <= i_load_data;
         r_bcnt <= {BC_W{1'b0}};
      end else if (i_shift) begin
         r_sreg <= {r_sreg[W-2:0], 1'b0};
         r_bcnt <= (r_bcnt == LAST) ? {BC_W{1'b0}} : (r_bcnt + ONE);
      end else begin
         r_sreg <= r_sreg;
         r_bcnt <= r_bcnt;
      end
   end

   assign o_msb  = r_sreg[W-1];
   assign o_done = (r_bcnt == LAST);

endmodule

// File: rtl/serial_reduce_unit.sv
// Frame-based sum / sum-of-squares / max / min reduction with an MSB-first serial result.
module serial_reduce_unit
   import serial_reduce_pkg::*;
#(
   parameter int DATA_W  = 4,
   parameter int N_WORDS = 4,
   parameter int OUT_W   = calc_out_w(DATA_W, N_WORDS)
) (
   input  logic            clk,
   input  logic            rst_n,
   serial_reduce_if.slave  bus
);
   localparam int              CNT_W    = $clog2(N_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

   state_e              r_state, w_state_nxt;
   mode_e               r_mode, w_mode_nxt;
   logic [OUT_W-1:0]    r_acc, w_acc_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                r_out_valid, r_out_data;

   logic [2*DATA_W-1:0] w_sq;
   logic [OUT_W-1:0]    w_d_ext, w_sq_ext, w_fold, w_seed;
   logic                w_load, w_shift, w_msb, w_done;

   assign w_sq     = {{DATA_W{1'b0}}, bus.in_data} * {{DATA_W{1'b0}}, bus.in_data};
   assign w_d_ext  = {{(OUT_W-DATA_W){1'b0}}, bus.in_data};
   assign w_sq_ext = {{(OUT_W-2*DATA_W){1'b0}}, w_sq};

   // Fold of the current word into the accumulator under the latched mode.
   always_comb begin
      w_fold = r_acc;
      case (r_mode)
         SUM:   w_fold = r_acc + w_d_ext;
         SQSUM: w_fold = r_acc + w_sq_ext;
         MAX: begin
            if (w_d_ext > r_acc) w_fold = w_d_ext;
            else                 w_fold = r_acc;
         end
         MIN: begin
            if (w_d_ext < r_acc) w_fold = w_d_ext;
            else                 w_fold = r_acc;
         end
         default: w_fold = r_acc;
      endcase
   end

   // Seed from word 0 uses the live mode input, since the mode register is not yet loaded.
   always_comb begin
      w_seed = w_d_ext;
      if (mode_e'(bus.in_mode) == SQSUM) w_seed = w_sq_ext;
      else                               w_seed = w_d_ext;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state, datapath next values and shifter controls.
   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_mode_nxt  = mode_e'(bus.in_mode);
               w_acc_nxt   = w_seed;
               w_cnt_nxt   = CNT_ONE;
               w_state_nxt = LOAD;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LOAD: begin
            if (bus.in_valid) begin
               w_acc_nxt = w_fold;
               w_cnt_nxt = r_cnt + CNT_ONE;
               if (r_cnt == LAST_IDX) w_state_nxt = CALC;
               else                   w_state_nxt = LOAD;
            end else begin
               // Short frame: drop everything and wait for a fresh frame.
               w_acc_nxt   = {OUT_W{1'b0}};
               w_cnt_nxt   = {CNT_W{1'b0}};
               w_state_nxt = IDLE;
            end
         end
         CALC: begin
            w_load      = 1'b1;
            w_state_nxt = SEND;
         end
         SEND: begin
            w_shift = 1'b1;
            if (w_done) w_state_nxt = IDLE;
            else        w_state_nxt = SEND;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Accumulator, word counter and frame mode registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= {OUT_W{1'b0}};
         r_cnt  <= {CNT_W{1'b0}};
         r_mode <= SUM;
      end else begin
         r_acc  <= w_acc_nxt;
         r_cnt  <= w_cnt_nxt;
         r_mode <= w_mode_nxt;
      end
   end

   piso_shift #(.W(OUT_W)) u_piso (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_load),
      .i_load_data (r_acc),
      .i_shift     (w_shift),
      .o_msb       (w_msb),
      .o_done      (w_done)
   );

   // Registered serial outputs; data is forced low outside the result window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 1'b0;
      end else begin
         r_out_valid <= (r_state == SEND);
         r_out_data  <= (r_state == SEND) && w_msb;
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_serial_reduce_unit.sv
// Directed and back-to-back frames on a default instance and an 8-bit x 16-word instance.
module tb_serial_reduce_unit;
   import serial_reduce_pkg::*;

   localparam int OW_A = 10;
   localparam int OW_B = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] drv_valid;
   logic [1:0] drv_mode [2];
   logic [7:0] drv_data [2];

   int     checks = 0;
   int     errors = 0;
   int     fw [16];
   longint q_exp_a [$];
   longint q_exp_b [$];
   time    q_t_a [$];
   time    q_t_b [$];

   serial_reduce_if #(.DATA_W(4)) bus_a ();
   serial_reduce_if #(.DATA_W(8)) bus_b ();

   assign bus_a.in_valid = drv_valid[0];
   assign bus_a.in_mode  = drv_mode[0];
   assign bus_a.in_data  = drv_data[0][3:0];
   assign bus_b.in_valid = drv_valid[1];
   assign bus_b.in_mode  = drv_mode[1];
   assign bus_b.in_data  = drv_data[1];

   serial_reduce_unit #(.DATA_W(4), .N_WORDS(4)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   serial_reduce_unit #(.DATA_W(8), .N_WORDS(16)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   always #5 clk = ~clk;

   function automatic logic ov(input int s);
      return (s == 1) ? bus_b.out_valid : bus_a.out_valid;
   endfunction

   function automatic logic od(input int s);
      return (s == 1) ? bus_b.out_data : bus_a.out_data;
   endfunction

   function automatic longint model(input int mode, input int n);
      longint acc;
      acc = (mode == 1) ? longint'(fw[0]) * fw[0] : longint'(fw[0]);
      for (int i = 1; i < n; i++) begin
         case (mode)
            0:       acc += fw[i];
            1:       acc += longint'(fw[i]) * fw[i];
            2:       if (fw[i] > acc) acc = fw[i];
            default: if (fw[i] < acc) acc = fw[i];
         endcase
      end
      return acc;
   endfunction

   // Drives n words from fw[]; a negative exp means no result is expected.
   task automatic send_frame(input int sel, input int mode, input int n, input int gap,
                             input bit toggle, input longint exp);
      repeat (gap) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         drv_valid[sel] = 1'b1;
         drv_mode[sel]  = (i > 0 && toggle) ? 2'(mode ^ 3) : 2'(mode);
         drv_data[sel]  = 8'(fw[i]);
      end
      @(negedge clk);
      drv_valid[sel] = 1'b0;
      drv_mode[sel]  = 2'($urandom);
      drv_data[sel]  = 8'($urandom);
      if (exp >= 0) begin
         if (sel == 1) begin q_exp_b.push_back(exp); q_t_b.push_back($time); end
         else          begin q_exp_a.push_back(exp); q_t_a.push_back($time); end
      end
   endtask

   task automatic recv_frame(input int sel, input int ow);
      int          n;
      int          lat;
      longint      exp;
      time         t0;
      bit          have;
      bit          hi;
      logic [63:0] got;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (ov(sel) === 1'b1) break;
      end
      checks++;
      assert (ov(sel) === 1'b1) else begin
         errors++;
         $error("FAIL rise_timeout dut%0d: out_valid=%b after %0d cycles, required 1", sel, ov(sel), n);
      end
      have = 1'b0;
      exp  = -1;
      t0   = 0;
      if (sel == 1 && q_exp_b.size() > 0) begin
         exp = q_exp_b.pop_front(); t0 = q_t_b.pop_front(); have = 1'b1;
      end else if (sel != 1 && q_exp_a.size() > 0) begin
         exp = q_exp_a.pop_front(); t0 = q_t_a.pop_front(); have = 1'b1;
      end
      if (ov(sel) !== 1'b1) return;
      checks++;
      assert (have === 1'b1) else begin
         errors++;
         $error("FAIL unexpected_result dut%0d: output with empty scoreboard, required none", sel);
      end
      lat = int'(($time - t0) / 10);
      checks++;
      assert (lat === 2) else begin
         errors++;
         $error("FAIL latency dut%0d: %0d cycles after in_valid fall, required 2", sel, lat);
      end
      hi  = 1'b1;
      got = 64'd0;
      for (int j = 0; j < ow; j++) begin
         if (j > 0) @(negedge clk);
         if (ov(sel) !== 1'b1) hi = 1'b0;
         got = {got[62:0], od(sel)};
      end
      checks++;
      assert (hi === 1'b1) else begin
         errors++;
         $error("FAIL valid_window dut%0d: out_valid dropped early, required %0d high cycles", sel, ow);
      end
      @(negedge clk);
      checks++;
      assert (ov(sel) === 1'b0 && od(sel) === 1'b0) else begin
         errors++;
         $error("FAIL valid_fall dut%0d: out_valid=%b out_data=%b, required 0 0", sel, ov(sel), od(sel));
      end
      checks++;
      assert (got === 64'(exp)) else begin
         errors++;
         $error("FAIL result dut%0d: got %0d, required %0d", sel, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int highs;
      drv_valid = 2'b00;
      drv_mode  = '{2'd0, 2'd0};
      drv_data  = '{8'd0, 8'd0};
      rst_n     = 1'b0;
      #2;
      checks++;
      assert (bus_a.out_valid === 1'b0) else begin errors++; $error("FAIL reset_valid_a: %b, required 0", bus_a.out_valid); end
      checks++;
      assert (bus_a.out_data === 1'b0) else begin errors++; $error("FAIL reset_data_a: %b, required 0", bus_a.out_data); end
      checks++;
      assert (bus_b.out_valid === 1'b0) else begin errors++; $error("FAIL reset_valid_b: %b, required 0", bus_b.out_valid); end
      checks++;
      assert (bus_b.out_data === 1'b0) else begin errors++; $error("FAIL reset_data_b: %b, required 0", bus_b.out_data); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      fw[0] = 1; fw[1] = 2; fw[2] = 3; fw[3] = 4;
      send_frame(0, 0, 4, 0, 1'b0, 64'd10);
      recv_frame(0, OW_A);

      for (int i = 0; i < 4; i++) fw[i] = 15;
      send_frame(0, 1, 4, 0, 1'b0, 64'd900);
      recv_frame(0, OW_A);

      fw[0] = 3; fw[1] = 9; fw[2] = 0; fw[3] = 7;
      send_frame(0, 2, 4, 0, 1'b1, 64'd9);
      recv_frame(0, OW_A);

      fw[0] = 8; fw[1] = 5; fw[2] = 12; fw[3] = 6;
      send_frame(0, 3, 4, 0, 1'b1, 64'd5);
      recv_frame(0, OW_A);

      // Aborted frame must produce nothing.
      fw[0] = 5; fw[1] = 5;
      send_frame(0, 0, 2, 0, 1'b0, -64'sd1);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_a.out_valid !== 1'b0) highs++;
      end
      checks++;
      assert (highs === 0) else begin errors++; $error("FAIL short_frame: %0d out_valid cycles, required 0", highs); end
      for (int i = 0; i < 4; i++) fw[i] = 1;
      send_frame(0, 0, 4, 0, 1'b0, 64'd4);
      recv_frame(0, OW_A);

      // Reset pulse in the middle of a result stream.
      for (int i = 0; i < 4; i++) fw[i] = 15;
      send_frame(0, 1, 4, 0, 1'b0, 64'd900);
      n = 0;
      while (n < 100 && bus_a.out_valid !== 1'b1) begin @(negedge clk); n++; end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      assert (bus_a.out_valid === 1'b0) else begin errors++; $error("FAIL midsend_reset_valid: %b, required 0", bus_a.out_valid); end
      checks++;
      assert (bus_a.out_data === 1'b0) else begin errors++; $error("FAIL midsend_reset_data: %b, required 0", bus_a.out_data); end
      q_exp_a.delete();
      q_t_a.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) fw[i] = int'($urandom_range(0, 15));
      send_frame(0, 2, 4, 0, 1'b0, model(2, 4));
      recv_frame(0, OW_A);

      fork
         begin : drv_a
            int m;
            for (int k = 0; k < 3; k++) begin
               m = int'($urandom_range(0, 3));
               for (int i = 0; i < 4; i++) fw[i] = int'($urandom_range(0, 15));
               send_frame(0, m, 4, (k == 0) ? 0 : OW_A, 1'b0, model(m, 4));
            end
         end
         begin : rcv_a
            repeat (3) recv_frame(0, OW_A);
         end
      join

      fork
         begin : drv_b
            int m;
            for (int i = 0; i < 16; i++) fw[i] = 255;
            send_frame(1, 1, 16, 0, 1'b0, 64'd1040400);
            m = int'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) fw[i] = int'($urandom_range(0, 255));
            send_frame(1, m, 16, OW_B, 1'b0, model(m, 16));
         end
         begin : rcv_b
            repeat (2) recv_frame(1, OW_B);
         end
      join

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_reduce_unit.md
# serial_reduce_unit

Parametrised serial-in, serial-out reduction engine. Accepts a frame of `N_WORDS` words of `DATA_W` bits on consecutive `in_valid` cycles, reduces them per a frame-latched mode (sum, sum of squares, max, min), then streams the `OUT_W`-bit result MSB-first on a 1-bit output under `out_valid`. Next-generation replacement for the fixed 4×4-bit → 10-bit serial-result block driven by the lab pattern benches. The default parameters keep that protocol and bit width, so existing benches still apply.

## Interface
- `DATA_W`, 4: input word width, ≥2
- `N_WORDS`, 4: words per frame, ≥2
- `OUT_W`, 2*DATA_W+$clog2(N_WORDS): serial result length (10 at defaults)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  frame word strobe; high for exactly `N_WORDS` consecutive cycles per frame
- `in_mode`  in  2  0 SUM, 1 SQSUM, 2 MAX, 3 MIN; sampled on first word only
- `in_data`  in  DATA_W  unsigned input word
- `out_valid`  out  1  high for exactly `OUT_W` consecutive cycles per result
- `out_data`  out  1  result bit, MSB first; 0 whenever `out_valid`=0

## Operation
- FSM states: IDLE, LOAD, CALC, SEND.
- IDLE, `in_valid`=1: latch `in_mode`, seed accumulator with word 0, set word count = 1, go to LOAD. Seed values:
  - SUM: word 0.
  - SQSUM: word 0².
  - MAX and MIN: word 0.
- LOAD, `in_valid`=1: fold word into accumulator and increment count. When the folded word is word `N_WORDS`-1, go to CALC. Fold operations:
  - SUM: acc+d.
  - SQSUM: acc+d*d.
  - MAX: larger of acc and d.
  - MIN: smaller of acc and d.
- LOAD, `in_valid`=0 (short frame): abort. Clear accumulator and count, go to IDLE, produce no output.
- CALC: one cycle. Load the accumulator into the `OUT_W` shift register, zero-extended (MAX/MIN occupy the low `DATA_W` bits). Clear the bit counter. Go to SEND.
- SEND: `out_valid`=1 and `out_data`=shift-register MSB. Shift left each cycle. After `OUT_W` bits, go to IDLE.
- Width rule: `OUT_W` holds the worst case N_WORDS*(2^DATA_W−1)² without overflow. No saturation logic.
- `in_valid` during CALC/SEND is a protocol violation. The block ignores it: no accumulation and no state change.
- `in_mode`/`in_data` are don't-care whenever they are not sampled.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, FSM=IDLE, all counters and accumulators 0.
- Reset is asserted asynchronously. All outputs drop within the same cycle, including mid-SEND.
- Word `i` is sampled at rising edge E+i. The last word is sampled at E+N_WORDS−1.
- Latency: the CALC bubble occupies the cycle after the last sample. `out_valid` rises at edge E+N_WORDS+1.
  - Checker counts 2 negedges from in_valid fall.
  - Ceiling: 100 cycles.
- `out_valid` falls at edge E+N_WORDS+1+OUT_W. `out_data`=0 from that edge.
- `out_valid` and `in_valid` never overlap when the protocol is obeyed.
- Back-to-back frames: a new frame may start the cycle after `out_valid` falls. Minimum frame period is N_WORDS+1+OUT_W cycles.

## Structure
- Package `serial_reduce_pkg`:
  - `mode_e` (SUM/SQSUM/MAX/MIN)
  - `state_e` (IDLE/LOAD/CALC/SEND)
  - function `calc_out_w(DATA_W, N_WORDS)` for the default `OUT_W`
- Sub-module `piso_shift #(W)`:
  - inputs: load, load data, shift enable
  - outputs: serial MSB and done
  - SEND exit is driven from `done`.
- The top level holds the FSM, word counter, mode register and reduction datapath. The squarer is combinational, DATA_W×DATA_W.

## Test plan
- Reset, then check `out_valid`=0 and `out_data`=0 before the clock is released. Pulse `rst_n` low mid-SEND → both outputs 0 immediately; the next frame is correct.
- SUM, words 1,2,3,4 → 10 = 0000001010 over 10 cycles; `out_valid` high exactly 10 cycles, then 0.
- SQSUM, words 15,15,15,15 → 900 = 1110000100. Worst case, no overflow.
- MAX, words 3,9,0,7 → 9 = 0000001001. MIN, words 8,5,12,6 → 5 = 0000000101. `in_mode` toggled after word 0 has no effect.
- Short frame: `in_valid` for 2 words (5,5), then a full SUM frame 1,1,1,1 → the only output is 4. No `out_valid` for the aborted frame.
- Parameter sweep with DATA_W=8, N_WORDS=16 (OUT_W=20), SQSUM of 255×16 → 1040400. Back-to-back frames at minimum period, latency checked each frame.
